// File: rtl/pause_pkg.sv
// Shared types and constants for the pause / screen-dim stage.
package pause_pkg;

    localparam int unsigned CW_DEFAULT     = 2;
    localparam logic [31:0] DIM_CYCLES_11M = 32'h068E_7780;

    typedef struct packed {
        logic [CW_DEFAULT-1:0] r;
        logic [CW_DEFAULT-1:0] g;
        logic [CW_DEFAULT-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pause_dim_ctrl_rgb_dimmer.sv
// Combinational pixel shader: per-channel intensity shift and blank zeroing.
module rgb_dimmer
    import pause_pkg::*;
#(
    parameter int unsigned CW    = CW_DEFAULT,
    parameter int unsigned SHIFT = 1
) (
    input  logic [3*CW-1:0] pix,
    input  logic            dim,
    input  logic            blank,
    output logic [3*CW-1:0] pix_c
);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pix_t;

    pix_t p_in;
    pix_t p_out;

    function automatic logic [CW-1:0] shade(input logic [CW-1:0] c, input logic d);
        return d ? CW'(c >> SHIFT) : c;
    endfunction

    assign p_in = pix;

    always_comb begin
        p_out = '0;
        if (!blank) begin
            p_out.r = shade(p_in.r, dim);
            p_out.g = shade(p_in.g, dim);
            p_out.b = shade(p_in.b, dim);
        end
    end

    assign pix_c = p_out;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges pause requests for the core and dims the picture at frame boundaries after a long idle pause.
module pause_dim_ctrl
    import pause_pkg::*;
#(
    parameter int unsigned CW         = CW_DEFAULT,
    parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_11M,
    parameter int unsigned DIM_SHIFT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_pause,
    input  logic            hs_pause,
    input  logic            osd_status,
    input  logic            cfg_osd_pause,
    input  logic            ce_pix,
    input  logic [3*CW-1:0] rgb_in,
    input  logic            hblank_in,
    input  logic            vblank_in,
    input  logic            hs_in,
    input  logic            vs_in,
    output logic [3*CW-1:0] rgb_out,
    output logic            hblank_out,
    output logic            vblank_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            pause,
    output logic            dimmed
);

    localparam int unsigned PW = 3 * CW;

    logic          btn_prev;
    logic          user_pause;
    logic          dim_act;
    logic [31:0]   timer;

    logic          btn_rise_c;
    logic          osd_req_c;
    logic          idle_pause_c;
    logic          dim_req_c;
    logic          vblank_rise_c;
    logic          blank_c;
    logic [PW-1:0] pix_c;

    assign btn_rise_c    = btn_pause & ~btn_prev;
    assign osd_req_c     = cfg_osd_pause & osd_status;
    assign idle_pause_c  = user_pause | osd_req_c;
    assign dim_req_c     = idle_pause_c & (timer == DIM_CYCLES);
    // vblank_out holds the previous ce_pix sample of vblank_in
    assign vblank_rise_c = ce_pix & vblank_in & ~vblank_out;
    assign blank_c       = hblank_in | vblank_in;

    // Button toggle and merged pause request
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev   <= 1'b1;
            user_pause <= 1'b0;
            pause      <= 1'b0;
        end else begin
            btn_prev   <= btn_pause;
            user_pause <= user_pause ^ btn_rise_c;
            pause      <= user_pause | hs_pause | osd_req_c;
        end
    end

    // Idle timer, saturating at the dim threshold
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= 32'd0;
        end else if (!idle_pause_c) begin
            timer <= 32'd0;
        end else if (timer != DIM_CYCLES) begin
            timer <= timer + 32'd1;
        end
    end

    // Dim state only changes at the start of vertical blank
    always_ff @(posedge clk) begin
        if (reset) begin
            dim_act <= 1'b0;
        end else if (vblank_rise_c) begin
            dim_act <= dim_req_c;
        end
    end

    assign dimmed = dim_act;

    rgb_dimmer #(
        .CW    (CW),
        .SHIFT (DIM_SHIFT)
    ) u_dimmer (
        .pix   (rgb_in),
        .dim   (dim_act),
        .blank (blank_c),
        .pix_c (pix_c)
    );

    // One ce_pix stage for pixel and timing so they stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out    <= '0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
        end else if (ce_pix) begin
            rgb_out    <= pix_c;
            hblank_out <= hblank_in;
            vblank_out <= vblank_in;
            hs_out     <= hs_in;
            vs_out     <= vs_in;
        end
    end

endmodule
